bibuf_dir_arbiter: RTL

//   Arbitrates between two requesters (A side, B side) that share one bidirectional

---
 rtl/bibuf_dir_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bibuf_dir_arbiter.sv
// Direction arbiter for a shared bidirectional buffer link: round-robin between A and B,
// with a fixed dead-time (buffer tri-stated) before every grant and an optional burst limit.
module bibuf_dir_arbiter #(
    parameter int TURN_CYC  = 2,
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b,
    output logic ctrl,
    output logic buf_en,
    output logic busy
);

    localparam int TW = ($clog2(TURN_CYC + 1) > 0) ? $clog2(TURN_CYC + 1) : 1;
    localparam int BW = ($clog2(MAX_BURST + 1) > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYC - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
    localparam bit BURST_LIMITED = (MAX_BURST != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            owner, owner_nxt;            // 1 = A owns / is about to own
    logic            last_owner, last_owner_nxt;
    logic [TW-1:0]   turn_cnt, turn_cnt_nxt;
    logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
    logic            req_own, req_oth;

    assign req_own = owner ? req_a : req_b;
    assign req_oth = owner ? req_b : req_a;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        turn_cnt_nxt   = turn_cnt;
        burst_cnt_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    state_nxt    = TURN;
                    owner_nxt    = (req_a && req_b) ? ~last_owner : req_a;
                    turn_cnt_nxt = TURN_LAST;
                end
            end
            TURN: begin
                if (turn_cnt == '0) begin
                    // Owner dropped its request during dead-time: give up without granting.
                    state_nxt     = req_own ? OWN : IDLE;
                    burst_cnt_nxt = '0;
                end else begin
                    turn_cnt_nxt = turn_cnt - 1'b1;
                end
            end
            OWN: begin
                if (!req_own) begin
                    last_owner_nxt = owner;
                    if (req_oth) begin
                        state_nxt    = TURN;
                        owner_nxt    = ~owner;
                        turn_cnt_nxt = TURN_LAST;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (BURST_LIMITED && burst_cnt == BURST_LAST && req_oth) begin
                    last_owner_nxt = owner;
                    state_nxt      = TURN;
                    owner_nxt      = ~owner;
                    turn_cnt_nxt   = TURN_LAST;
                end else if (BURST_LIMITED && burst_cnt != BURST_LAST) begin
                    // Saturates at the limit so a late contender is served at once.
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            turn_cnt   <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            turn_cnt   <= turn_cnt_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            ctrl    <= 1'b0;
            buf_en  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            grant_a <= (state_nxt == OWN) && owner_nxt;
            grant_b <= (state_nxt == OWN) && !owner_nxt;
            ctrl    <= owner_nxt;
            buf_en  <= (state_nxt == OWN);
            busy    <= (state_nxt != IDLE);
        end
    end

endmodule
